// File: rtl/pipe_stage_buf.sv
// pipe_stage_buf: pipeline-stage register with a valid/ready handshake and a
// 2-entry skid buffer. Carries NUM_FIELDS packed fields of WIDTH bits each;
// field k occupies out_data[k*WIDTH +: WIDTH]. Data passes through bit-exact.
//
// Ports:
//   clk       in   rising-edge clock
//   rst       in   asynchronous, active-high reset
//   flush     in   synchronous flush; drops all held entries and clears data
//   in_valid  in   upstream has data
//   in_ready  out  stage can accept; depends only on registered state
//   in_data   in   upstream packed fields
//   out_valid out  stage holds data for downstream
//   out_ready in   downstream accepts
//   out_data  out  packed fields to downstream
//   occupancy out  entries held (0, 1 or 2)
module pipe_stage_buf #(
   parameter int WIDTH      = 32,
   parameter int NUM_FIELDS = 17,
   parameter int DATA_W     = WIDTH * NUM_FIELDS
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [1:0]        occupancy
);

   // EMPTY: main_v=0 skid_v=0; ONE: main_v=1 skid_v=0; FULL: both valid.
   // The illegal "skid valid without main valid" combination is unencodable.
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W-1:0] main_data_q, main_data_d;
   logic [DATA_W-1:0] skid_data_q, skid_data_d;
   logic              accept;
   logic              pop;

   // Handshake terms come straight from registered state, so neither
   // in_ready nor out_valid has a combinational path from the other side.
   assign accept = in_valid & (state_q != FULL);
   assign pop    = out_ready & (state_q != EMPTY);

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= EMPTY;
         main_data_q <= '0;
         skid_data_q <= '0;
      end else begin
         state_q     <= state_d;
         main_data_q <= main_data_d;
         skid_data_q <= skid_data_d;
      end
   end

   // Next-state and datapath
   always_comb begin
      state_d     = state_q;
      main_data_d = main_data_q;
      skid_data_d = skid_data_q;
      if (flush) begin
         // Flush wins over accept/pop; a concurrent pop still completes
         // downstream, a concurrent input beat is dropped.
         state_d     = EMPTY;
         main_data_d = '0;
         skid_data_d = '0;
      end else begin
         unique case (state_q)
            EMPTY: begin
               if (accept) begin
                  main_data_d = in_data;
                  state_d     = ONE;
               end
            end
            ONE: begin
               if (accept && pop) begin
                  main_data_d = in_data;
               end else if (accept) begin
                  // New beat parks behind main so ordering stays FIFO.
                  skid_data_d = in_data;
                  state_d     = FULL;
               end else if (pop) begin
                  state_d = EMPTY;
               end
            end
            FULL: begin
               if (pop) begin
                  main_data_d = skid_data_q;
                  state_d     = ONE;
               end
            end
            default: state_d = EMPTY;
         endcase
      end
   end

   // Outputs
   always_comb begin
      out_valid = (state_q != EMPTY);
      in_ready  = (state_q != FULL);
      unique case (state_q)
         EMPTY:   occupancy = 2'd0;
         ONE:     occupancy = 2'd1;
         FULL:    occupancy = 2'd2;
         default: occupancy = 2'd0;
      endcase
   end

   assign out_data = main_data_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
module tb_pipe_stage_buf;

   localparam int WIDTH      = 8;
   localparam int NUM_FIELDS = 3;
   localparam int DATA_W     = WIDTH * NUM_FIELDS;

   logic              clk;
   logic              rst;
   logic              flush;
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [1:0]        occupancy;

   int total = 0;
   int bad   = 0;

   pipe_stage_buf #(
      .WIDTH      (WIDTH),
      .NUM_FIELDS (NUM_FIELDS)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge and settle 1 time unit after it.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [DATA_W-1:0] model_q[$];
   logic              m_acc;
   logic              m_pop;

   initial begin
      rst       = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      in_data   = '0;
      step();
      step();
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      check("rst_occ",       32'(occupancy), 32'd0);
      check("rst_out_data",  32'(out_data),  32'd0);
      rst = 1'b0;

      // Reset asserted mid-FULL, between edges
      in_valid = 1'b1; in_data = 24'h11;
      step();
      in_data = 24'h22;
      step();
      in_valid = 1'b0;
      check("fill_occ",      32'(occupancy), 32'd2);
      check("fill_in_ready", 32'(in_ready),  32'd0);
      check("fill_out_data", 32'(out_data),  32'h11);
      #2 rst = 1'b1;
      #1;
      check("arst_out_valid", 32'(out_valid), 32'd0);
      check("arst_out_data",  32'(out_data),  32'd0);
      check("arst_occ",       32'(occupancy), 32'd0);
      check("arst_in_ready",  32'(in_ready),  32'd1);
      rst = 1'b0;
      step();

      // Streaming at full rate
      out_ready = 1'b1;
      in_valid  = 1'b1;
      check("stream_pre_valid", 32'(out_valid), 32'd0);
      for (int i = 1; i <= 5; i++) begin
         in_data = 24'(i);
         step();
         check("stream_valid", 32'(out_valid), 32'd1);
         check("stream_data",  32'(out_data),  32'(i));
         check("stream_occ",   32'(occupancy), 32'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drain_valid", 32'(out_valid), 32'd0);
      check("stream_drain_occ",   32'(occupancy), 32'd0);

      // Back-pressure
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 24'hA;
      step();
      check("bp_occ1",  32'(occupancy), 32'd1);
      check("bp_data1", 32'(out_data),  32'hA);
      in_data = 24'hB;
      step();
      check("bp_occ2",      32'(occupancy), 32'd2);
      check("bp_in_ready0", 32'(in_ready),  32'd0);
      check("bp_data2",     32'(out_data),  32'hA);
      in_data = 24'hC;
      step();
      check("bp_ignore_occ",  32'(occupancy), 32'd2);
      check("bp_ignore_data", 32'(out_data),  32'hA);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      step();
      check("bp_pop1_data",  32'(out_data),  32'hB);
      check("bp_pop1_ready", 32'(in_ready),  32'd1);
      check("bp_pop1_occ",   32'(occupancy), 32'd1);
      step();
      check("bp_pop2_valid", 32'(out_valid), 32'd0);
      check("bp_pop2_occ",   32'(occupancy), 32'd0);

      // Flush while FULL with a simultaneous input beat
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 24'h5;
      step();
      in_data = 24'h6;
      step();
      check("fl_full_occ", 32'(occupancy), 32'd2);
      flush = 1'b1; in_data = 24'h7;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_occ",      32'(occupancy), 32'd0);
      check("fl_valid",    32'(out_valid), 32'd0);
      check("fl_data",     32'(out_data),  32'd0);
      check("fl_in_ready", 32'(in_ready),  32'd1);
      out_ready = 1'b1;
      step();
      check("fl_no7_valid", 32'(out_valid), 32'd0);
      check("fl_no7_data",  32'(out_data),  32'd0);

      // Field packing
      out_ready = 1'b0;
      in_valid  = 1'b1; in_data = 24'h332211;
      step();
      in_valid = 1'b0;
      check("pack_f0", 32'(out_data[0*WIDTH +: WIDTH]), 32'h11);
      check("pack_f1", 32'(out_data[1*WIDTH +: WIDTH]), 32'h22);
      check("pack_f2", 32'(out_data[2*WIDTH +: WIDTH]), 32'h33);
      out_ready = 1'b1;
      step();
      check("pack_drain", 32'(occupancy), 32'd0);

      // Random valid/ready against a reference queue
      model_q.delete();
      for (int c = 0; c < 1000; c++) begin
         in_valid  = 1'($urandom_range(0, 1));
         out_ready = 1'($urandom_range(0, 1));
         in_data   = 24'($urandom);
         m_acc = in_valid && (model_q.size() < 2);
         m_pop = out_ready && (model_q.size() > 0);
         step();
         if (m_pop) void'(model_q.pop_front());
         if (m_acc) model_q.push_back(in_data);
         check("rnd_occ",      32'(occupancy), 32'(model_q.size()));
         check("rnd_valid",    32'(out_valid), 32'(model_q.size() > 0));
         check("rnd_in_ready", 32'(in_ready),  32'(model_q.size() < 2));
         if (model_q.size() > 0)
            check("rnd_data", 32'(out_data), 32'(model_q[0]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
